// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time for the current PC and queues
// returned {pc, instr} pairs in a small FIFO for decode. Flush drops queued and in-flight work.
module instr_fetch_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_i,
   output logic             pc_advance_o,
   input  logic             flush_i,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic             if_valid_o,
   input  logic             if_ready_i,
   output logic [WIDTH-1:0] if_pc_o,
   output logic [WIDTH-1:0] if_instr_o
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
   localparam logic [CntW-1:0] DepthM1Cnt = CntW'(DEPTH - 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StReq, StRsp, StDrop} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic [CntW-1:0]  count_q, count_d, count_pop;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [WIDTH-1:0] instr_mem_q [DEPTH];
   logic             push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign if_valid_o  = (count_q != '0);
   assign pop         = if_valid_o & if_ready_i & ~flush_i;
   assign count_pop   = count_q - CntW'(pop);
   assign imem_addr_o = imem_req_o ? {pc_i[WIDTH-1:2], 2'b00} : '0;
   assign if_pc_o     = if_valid_o ? pc_mem_q[rd_ptr_q] : '0;
   assign if_instr_o  = if_valid_o ? instr_mem_q[rd_ptr_q] : '0;

   always_comb begin
      state_d      = state_q;
      req_pc_d     = req_pc_q;
      push         = 1'b0;
      pc_advance_o = 1'b0;
      imem_req_o   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!flush_i && (count_pop < DepthCnt)) state_d = StReq;
         end
         StReq: begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) begin
               if (flush_i) begin
                  state_d = StDrop;
               end else begin
                  pc_advance_o = 1'b1;
                  req_pc_d     = pc_i;
                  state_d      = StRsp;
               end
            end else if (flush_i) begin
               state_d = StIdle;
            end
         end
         StRsp: begin
            if (imem_rvalid_i) begin
               if (flush_i) begin
                  state_d = StIdle;
               end else begin
                  push = 1'b1;
                  // Re-request only if a slot is still free once this push lands.
                  state_d = (count_pop < DepthM1Cnt) ? StReq : StIdle;
               end
            end else if (flush_i) begin
               state_d = StDrop;
            end
         end
         StDrop: begin
            if (imem_rvalid_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d  = count_pop + CntW'(push);
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      if (flush_i) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         req_pc_q <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// queue-based model of the fetch stream and a memory responder.
module tb_instr_fetch_unit;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] pc_i;
   logic             pc_advance_o;
   logic             flush_i;
   logic             imem_req_o;
   logic [WIDTH-1:0] imem_addr_o;
   logic             imem_gnt_i;
   logic             imem_rvalid_i;
   logic [WIDTH-1:0] imem_rdata_i;
   logic             if_valid_o;
   logic             if_ready_i;
   logic [WIDTH-1:0] if_pc_o;
   logic [WIDTH-1:0] if_instr_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .pc_advance_o  (pc_advance_o),
      .flush_i       (flush_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_ready_i    (if_ready_i),
      .if_pc_o       (if_pc_o),
      .if_instr_o    (if_instr_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pc_i = '0; flush_i = 1'b0; imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; if_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc_i = $urandom(); flush_i = 1'b0; imem_gnt_i = 1'b1;
      imem_rvalid_i = 1'b1; imem_rdata_i = $urandom(); if_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req_o); end
      checks++; if (imem_addr_o !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", imem_addr_o); end
      checks++; if (pc_advance_o !== 1'b0) begin failures++; $display("FAIL reset_adv got=%b want=0", pc_advance_o); end
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", if_valid_o); end
      checks++; if (if_pc_o !== '0) begin failures++; $display("FAIL reset_pc got=%h want=0", if_pc_o); end
      checks++; if (if_instr_o !== '0) begin failures++; $display("FAIL reset_instr got=%h want=0", if_instr_o); end
   endtask

   task automatic test_latency();
      do_reset();
      #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL lat_c0_req got=%b want=0", imem_req_o); end
      step();
      imem_gnt_i = 1'b1; #1;
      checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL lat_c1_req got=%b want=1", imem_req_o); end
      checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL lat_c1_addr got=%h want=0", imem_addr_o); end
      checks++; if (pc_advance_o !== 1'b1) begin failures++; $display("FAIL lat_c1_adv got=%b want=1", pc_advance_o); end
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; pc_i = 32'h4; #1;
      checks++; if (pc_advance_o !== 1'b0) begin failures++; $display("FAIL lat_c2_adv got=%b want=0", pc_advance_o); end
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL lat_c2_valid got=%b want=0", if_valid_o); end
      step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL lat_c3_valid got=%b want=1", if_valid_o); end
      checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL lat_c3_pc got=%h want=0", if_pc_o); end
      checks++; if (if_instr_o !== 32'h0050_0093) begin failures++; $display("FAIL lat_c3_instr got=%h want=00500093", if_instr_o); end
   endtask

   task automatic test_backpressure();
      logic             pend;
      logic [WIDTH-1:0] pend_d;
      logic [WIDTH-1:0] exp_i [$];
      int               grants;
      bit               seen;
      pend = 1'b0; pend_d = '0; grants = 0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         imem_gnt_i = imem_req_o; imem_rvalid_i = pend; imem_rdata_i = pend_d;
         #1;
         pend = imem_gnt_i;
         if (imem_gnt_i) begin pend_d = $urandom(); exp_i.push_back(pend_d); end
         if (pc_advance_o) grants++;
         step();
         if (pc_advance_o === 1'b0 && grants > 0 && pc_i != 32'(4 * grants)) pc_i = 32'(4 * grants);
      end
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; #1;
      checks++; if (grants != 2) begin failures++; $display("FAIL bp_grants got=%0d want=2", grants); end
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%b want=0", imem_req_o); end
      checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h want=0", if_pc_o); end
      if (exp_i.size() >= 2) begin
         checks++; if (if_instr_o !== exp_i[0]) begin failures++; $display("FAIL bp_head_instr got=%h want=%h", if_instr_o, exp_i[0]); end
      end
      if_ready_i = 1'b1;
      step();
      if_ready_i = 1'b0; #1;
      checks++; if (if_pc_o !== 32'h4) begin failures++; $display("FAIL bp_second_pc got=%h want=4", if_pc_o); end
      if (exp_i.size() >= 2) begin
         checks++; if (if_instr_o !== exp_i[1]) begin failures++; $display("FAIL bp_second_instr got=%h want=%h", if_instr_o, exp_i[1]); end
      end
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         if (imem_req_o === 1'b1) seen = 1'b1;
         else step();
      end
      checks++; if (!seen) begin failures++; $display("FAIL bp_resume got=no_req want=req"); end
      checks++; if (imem_addr_o !== 32'h8) begin failures++; $display("FAIL bp_resume_addr got=%h want=8", imem_addr_o); end
   endtask

   task automatic test_gnt_delay();
      logic [WIDTH-1:0] pc, d;
      int advs;
      advs = 0;
      do_reset();
      pc = $urandom() & 32'hFFFF_FFFC; pc_i = pc;
      step();
      for (int c = 1; c <= 4; c++) begin
         imem_gnt_i = (c == 4); #1;
         checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL gd_req_c%0d got=%b want=1", c, imem_req_o); end
         checks++; if (imem_addr_o !== pc) begin failures++; $display("FAIL gd_addr_c%0d got=%h want=%h", c, imem_addr_o, pc); end
         if (pc_advance_o === 1'b1) advs++;
         step();
      end
      d = $urandom();
      imem_gnt_i = 1'b0; pc_i = pc + 4; imem_rvalid_i = 1'b1; imem_rdata_i = d; #1;
      if (pc_advance_o === 1'b1) advs++;
      step();
      imem_rvalid_i = 1'b0; #1;
      if (pc_advance_o === 1'b1) advs++;
      checks++; if (advs != 1) begin failures++; $display("FAIL gd_adv_pulses got=%0d want=1", advs); end
      checks++; if (if_pc_o !== pc) begin failures++; $display("FAIL gd_head_pc got=%h want=%h", if_pc_o, pc); end
      checks++; if (if_instr_o !== d) begin failures++; $display("FAIL gd_head_instr got=%h want=%h", if_instr_o, d); end
   endtask

   task automatic test_flush_rsp();
      logic [WIDTH-1:0] d1;
      do_reset();
      step();
      imem_gnt_i = 1'b1; #1; step();
      imem_gnt_i = 1'b0; pc_i = 32'h4; imem_rvalid_i = 1'b1; imem_rdata_i = $urandom(); #1; step();
      imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; #1;
      checks++; if (pc_advance_o !== 1'b1) begin failures++; $display("FAIL fr_second_adv got=%b want=1", pc_advance_o); end
      step();
      imem_gnt_i = 1'b0; pc_i = 32'h8; flush_i = 1'b1; #1;
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL fr_queued got=%b want=1", if_valid_o); end
      step();
      flush_i = 1'b0; pc_i = 32'h100; #1;
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL fr_valid_after got=%b want=0", if_valid_o); end
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL fr_drop_req got=%b want=0", imem_req_o); end
      step();
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL fr_late_req got=%b want=0", imem_req_o); end
      step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL fr_late_discard got=%b want=0", if_valid_o); end
      step();
      imem_gnt_i = 1'b1; #1;
      checks++; if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin failures++; $display("FAIL fr_redirect_addr got=%h want=100", imem_addr_o); end
      step();
      d1 = $urandom();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = d1; pc_i = 32'h104; #1; step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_pc_o !== 32'h100) begin failures++; $display("FAIL fr_redirect_pc got=%h want=100", if_pc_o); end
      checks++; if (if_instr_o !== d1) begin failures++; $display("FAIL fr_redirect_instr got=%h want=%h", if_instr_o, d1); end
   endtask

   task automatic test_flush_gnt();
      logic [WIDTH-1:0] d;
      do_reset();
      step();
      imem_gnt_i = 1'b1; flush_i = 1'b1; #1;
      checks++; if (pc_advance_o !== 1'b0) begin failures++; $display("FAIL fg_adv got=%b want=0", pc_advance_o); end
      step();
      imem_gnt_i = 1'b0; flush_i = 1'b0; pc_i = 32'h202; #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL fg_drop_req got=%b want=0", imem_req_o); end
      step();
      imem_rvalid_i = 1'b1; imem_rdata_i = $urandom(); #1; step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL fg_discard got=%b want=0", if_valid_o); end
      step();
      imem_gnt_i = 1'b1; #1;
      checks++; if (imem_addr_o !== 32'h200) begin failures++; $display("FAIL fg_aligned_addr got=%h want=200", imem_addr_o); end
      checks++; if (pc_advance_o !== 1'b1) begin failures++; $display("FAIL fg_refetch_adv got=%b want=1", pc_advance_o); end
      step();
      d = $urandom();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = d; pc_i = 32'h206; #1; step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_pc_o[WIDTH-1:2] !== 30'h80) begin failures++; $display("FAIL fg_head_pc got=%h want=200", if_pc_o); end
      checks++; if (if_instr_o !== d) begin failures++; $display("FAIL fg_head_instr got=%h want=%h", if_instr_o, d); end
   endtask

   task automatic test_rst_rsp();
      do_reset();
      step();
      imem_gnt_i = 1'b1; #1; step();
      imem_gnt_i = 1'b0; pc_i = 32'h4; imem_rvalid_i = 1'b1; imem_rdata_i = $urandom(); #1; step();
      imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; #1; step();
      imem_gnt_i = 1'b0; rst = 1'b1; #1;
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL rr_pre_valid got=%b want=1", if_valid_o); end
      step();
      rst = 1'b0; pc_i = 32'h0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678; #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rr_req got=%b want=0", imem_req_o); end
      checks++; if (imem_addr_o !== '0) begin failures++; $display("FAIL rr_addr got=%h want=0", imem_addr_o); end
      checks++; if (pc_advance_o !== 1'b0) begin failures++; $display("FAIL rr_adv got=%b want=0", pc_advance_o); end
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL rr_valid got=%b want=0", if_valid_o); end
      checks++; if (if_pc_o !== '0 || if_instr_o !== '0) begin failures++; $display("FAIL rr_head got=%h/%h want=0/0", if_pc_o, if_instr_o); end
      step();
      imem_rvalid_i = 1'b0; #1;
      checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL rr_stray got=%b want=0", if_valid_o); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] q_pc [$];
      logic [WIDTH-1:0] q_in [$];
      logic [WIDTH-1:0] pc, out_pc, out_data;
      bit               out_v, out_disc, exp_v;
      int unsigned      out_dly;
      int               grants, pushes;
      pc = '0; out_pc = '0; out_data = '0; out_v = 1'b0; out_disc = 1'b0; out_dly = 0;
      grants = 0; pushes = 0;
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         pc_i          = pc;
         flush_i       = ($urandom_range(0, 15) == 0);
         if_ready_i    = ($urandom_range(0, 3) != 0);
         imem_gnt_i    = imem_req_o & 1'($urandom_range(0, 1));
         imem_rvalid_i = out_v && (out_dly == 0);
         imem_rdata_i  = imem_rvalid_i ? out_data : $urandom();
         #1;
         exp_v = (q_pc.size() != 0);
         checks++; if (if_valid_o !== exp_v) begin failures++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, if_valid_o, exp_v); end
         checks++;
         if (exp_v ? (if_pc_o !== q_pc[0] || if_instr_o !== q_in[0]) : (if_pc_o !== '0 || if_instr_o !== '0)) begin
            failures++;
            $display("FAIL rnd_head c=%0d got=%h/%h want=%h/%h", c, if_pc_o, if_instr_o,
                     exp_v ? q_pc[0] : 32'h0, exp_v ? q_in[0] : 32'h0);
         end
         checks++; if (pc_advance_o !== (imem_gnt_i && !flush_i)) begin failures++; $display("FAIL rnd_adv c=%0d got=%b want=%b", c, pc_advance_o, imem_gnt_i && !flush_i); end
         if (imem_req_o === 1'b1) begin
            checks++; if (imem_addr_o !== {pc[WIDTH-1:2], 2'b00}) begin failures++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr_o, {pc[WIDTH-1:2], 2'b00}); end
            checks++; if (out_v) begin failures++; $display("FAIL rnd_outstanding c=%0d got=2 want=1", c); end
            checks++; if (q_pc.size() >= DEPTH) begin failures++; $display("FAIL rnd_req_full c=%0d got=req want=no_req", c); end
         end
         if (flush_i) begin
            q_pc.delete(); q_in.delete();
         end else begin
            if (exp_v && if_ready_i) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
            if (imem_rvalid_i && !out_disc) begin q_pc.push_back(out_pc); q_in.push_back(out_data); pushes++; end
         end
         if (imem_rvalid_i) begin
            out_v = 1'b0;
         end else if (out_v) begin
            if (flush_i) out_disc = 1'b1;
            out_dly--;
         end
         if (imem_gnt_i) begin
            out_v = 1'b1; out_disc = flush_i; out_pc = pc; out_data = $urandom();
            out_dly = $urandom_range(0, 2);
            if (!flush_i) grants++;
         end
         if (flush_i) pc = $urandom() & 32'hFFFF_FFFC;
         else if (imem_gnt_i) pc = pc + 4;
         step();
      end
      checks++; if (grants < 150) begin failures++; $display("FAIL rnd_progress got=%0d want>=150", grants); end
      checks++; if (pushes < 100) begin failures++; $display("FAIL rnd_delivered got=%0d want>=100", pushes); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_backpressure();
      test_gnt_delay();
      test_flush_rsp();
      test_flush_gnt();
      test_rst_rsp();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
